// File: rtl/alu_simd_pipe.sv
// alu_simd_pipe: handshaked, registered SIMD ALU with per-lane flags and signed saturation.
// Define ALU_SIMD_DIV_EN to build in the iterative unsigned divider (DIVU/REMU).
module alu_simd_pipe #(
    parameter int LANE_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  op,
    input  logic                        sat,
    input  logic [LANE_WIDTH*LANES-1:0] operand_a,
    input  logic [LANE_WIDTH*LANES-1:0] operand_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_WIDTH*LANES-1:0] result,
    output logic [LANES-1:0]            zero,
    output logic [LANES-1:0]            negative,
    output logic [LANES-1:0]            carry,
    output logic [LANES-1:0]            overflow,
    output logic                        illegal
);
    localparam int W   = LANE_WIDTH * LANES;
    localparam int SHW = $clog2(LANE_WIDTH);
    localparam int MSB = LANE_WIDTH - 1;

    typedef enum logic [0:0] {IDLE, DIV_RUN} state_t;
    state_t state, state_next;

    logic             out_free, accept, is_div_op, op_illegal, div_load;
    logic [W-1:0]     alu_res;
    logic [LANES-1:0] alu_zero, alu_neg, alu_carry, alu_ovf;

    assign out_free = !out_valid || out_ready;
    assign in_ready = rst_n && (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;

`ifdef ALU_SIMD_DIV_EN
    assign is_div_op  = (op == 4'hB) || (op == 4'hC);
    assign op_illegal = (op >= 4'hD);

    localparam int CW = $clog2(LANE_WIDTH + 1);
    logic [W-1:0]     div_q, div_r, div_b, step_q, step_r, div_res;
    logic [LANES-1:0] div_zero, div_neg;
    logic             div_rem, div_done;
    logic [CW-1:0]    div_cnt;

    // Once all quotient bits are computed the registers hold the answer; on the
    // final iteration the answer is taken straight from the step logic instead.
    assign div_done = (div_cnt == CW'(LANE_WIDTH));
    assign div_load = (state == DIV_RUN) && (div_cnt >= CW'(LANE_WIDTH - 1)) && out_free;
    assign div_res  = div_rem ? (div_done ? div_r : step_r) : (div_done ? div_q : step_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            div_r   <= '0;
            div_b   <= '0;
            div_rem <= 1'b0;
            div_cnt <= '0;
        end else if (accept && is_div_op) begin
            div_q   <= operand_a;
            div_r   <= '0;
            div_b   <= operand_b;
            div_rem <= (op == 4'hC);
            div_cnt <= '0;
        end else if ((state == DIV_RUN) && !div_done) begin
            div_q   <= step_q;
            div_r   <= step_r;
            div_cnt <= div_cnt + CW'(1);
        end
    end
`else
    assign is_div_op  = 1'b0;
    assign op_illegal = (op >= 4'hB);
    assign div_load   = 1'b0;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [MSB:0]        a, b, r;
        logic [LANE_WIDTH:0] sum, dif;
        logic [SHW-1:0]      sh;
        logic                c, v;

        assign a  = operand_a[i*LANE_WIDTH +: LANE_WIDTH];
        assign b  = operand_b[i*LANE_WIDTH +: LANE_WIDTH];
        assign sh = b[SHW-1:0];

        always_comb begin
            sum = {1'b0, a} + {1'b0, b};
            dif = {1'b0, a} - {1'b0, b};
            r   = '0;
            c   = 1'b0;
            v   = 1'b0;
            case (op)
                4'h0: begin
                    r = sum[MSB:0];
                    c = sum[LANE_WIDTH];
                    v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
                end
                4'h1: begin
                    r = dif[MSB:0];
                    c = !dif[LANE_WIDTH];
                    v = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
                end
                4'h2:    r = a & b;
                4'h3:    r = a | b;
                4'h4:    r = a ^ b;
                4'h5:    r = a << sh;
                4'h6:    r = a >> sh;
                4'h7:    r = $signed(a) >>> sh;
                4'h8:    r = ($signed(a) < $signed(b)) ? a : b;
                4'h9:    r = ($signed(a) > $signed(b)) ? a : b;
                4'hA:    r = a * b;
                default: r = '0;
            endcase
            // Only ADD/SUB can raise v, so saturation is naturally limited to them.
            if (sat && v) r = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end

        assign alu_res[i*LANE_WIDTH +: LANE_WIDTH] = r;
        assign alu_carry[i] = c;
        assign alu_ovf[i]   = v;
        assign alu_zero[i]  = (r == '0);
        assign alu_neg[i]   = r[MSB];

`ifdef ALU_SIMD_DIV_EN
        // Restoring step: bit LANE_WIDTH of the trial difference is the borrow.
        logic [LANE_WIDTH:0] shifted, trial;
        assign shifted = {div_r[i*LANE_WIDTH +: LANE_WIDTH], div_q[i*LANE_WIDTH + MSB]};
        assign trial   = shifted - {1'b0, div_b[i*LANE_WIDTH +: LANE_WIDTH]};
        assign step_r[i*LANE_WIDTH +: LANE_WIDTH] = trial[LANE_WIDTH] ? shifted[MSB:0] : trial[MSB:0];
        assign step_q[i*LANE_WIDTH +: LANE_WIDTH] = {div_q[i*LANE_WIDTH +: MSB], !trial[LANE_WIDTH]};
        assign div_zero[i] = (div_res[i*LANE_WIDTH +: LANE_WIDTH] == '0);
        assign div_neg[i]  = div_res[i*LANE_WIDTH + MSB];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_div_op) state_next = DIV_RUN;
            DIV_RUN: if (div_load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= '0;
            negative  <= '0;
            carry     <= '0;
            overflow  <= '0;
            illegal   <= 1'b0;
`ifdef ALU_SIMD_DIV_EN
        end else if (div_load) begin
            out_valid <= 1'b1;
            result    <= div_res;
            zero      <= div_zero;
            negative  <= div_neg;
            carry     <= '0;
            overflow  <= '0;
            illegal   <= 1'b0;
`endif
        end else if (accept && !is_div_op) begin
            out_valid <= 1'b1;
            illegal   <= op_illegal;
            result    <= op_illegal ? '0 : alu_res;
            zero      <= op_illegal ? '0 : alu_zero;
            negative  <= op_illegal ? '0 : alu_neg;
            carry     <= op_illegal ? '0 : alu_carry;
            overflow  <= op_illegal ? '0 : alu_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
